// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Optional feature macro used across this slice: DIV_ZERO_FLAG_EN.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Iteration counter width for an arbitrary operand width (never below one bit).
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result handshake bundle for seq_restoring_divider.
// div_by_zero exists only when DIV_ZERO_FLAG_EN is defined.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic             div_by_zero;
`endif

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder
`ifdef DIV_ZERO_FLAG_EN
        , input div_by_zero
`endif
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder
`ifdef DIV_ZERO_FLAG_EN
        , output div_by_zero
`endif
    );

endinterface

// File: rtl/seq_restoring_divider_ripple_sub.sv
// Combinational ripple subtractor: a - b computed as a + ~b + 1 with
// propagate/generate cells; borrow is the inverted final carry.
module ripple_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W-1:0] bn;
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    assign c[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_cell
            assign bn[gi]   = ~b[gi];
            assign p[gi]    = a[gi] ^ bn[gi];
            assign g[gi]    = a[gi] & bn[gi];
            assign diff[gi] = p[gi] ^ c[gi];
            assign c[gi+1]  = g[gi] | (p[gi] & c[gi]);
        end
    endgenerate

    assign borrow = ~c[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// Define DIV_ZERO_FLAG_EN to short-cut zero divisors and expose div_by_zero.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_restoring_divider_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg,     q_next;
    logic [WIDTH-1:0] rem_reg,   rem_next;
    logic [WIDTH-1:0] dvs_reg,   dvs_next;
    logic [CW-1:0]    cnt_reg,   cnt_next;
`ifdef DIV_ZERO_FLAG_EN
    logic             dbz_reg,   dbz_next;
`endif

    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;
    logic           borrow;
    logic           restore;

    assign partial = {rem_reg, q_reg[WIDTH-1]};

    ripple_sub #(.W(WIDTH + 1)) u_sub (
        .a      (partial),
        .b      ({1'b0, dvs_reg}),
        .diff   (trial),
        .borrow (borrow)
    );

    // A set MSB on a non-borrowing trial cannot happen while rem < divisor;
    // folding it in lets the stored remainder stay WIDTH bits.
    assign restore = borrow | trial[WIDTH];

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        rem_next   = rem_reg;
        dvs_next   = dvs_reg;
        cnt_next   = cnt_reg;
`ifdef DIV_ZERO_FLAG_EN
        dbz_next   = dbz_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    q_next     = bus.dividend;
                    dvs_next   = bus.divisor;
                    rem_next   = '0;
                    cnt_next   = CW'(WIDTH - 1);
                    state_next = CALC;
`ifdef DIV_ZERO_FLAG_EN
                    if (bus.divisor == '0) begin
                        q_next     = '1;
                        rem_next   = bus.dividend;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end
`endif
                end
            end
            CALC: begin
                q_next   = {q_reg[WIDTH-2:0], ~restore};
                rem_next = restore ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
`ifdef DIV_ZERO_FLAG_EN
                    dbz_next   = 1'b0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            rem_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dbz_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            rem_reg   <= rem_next;
            dvs_reg   <= dvs_next;
            cnt_reg   <= cnt_next;
`ifdef DIV_ZERO_FLAG_EN
            dbz_reg   <= dbz_next;
`endif
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.quotient  = q_reg;
    assign bus.remainder = rem_reg;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.div_by_zero = dbz_reg;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and swept checks for seq_restoring_divider at WIDTH=8.
// Builds with or without DIV_ZERO_FLAG_EN.
module tb_seq_restoring_divider;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_restoring_divider_if #(.WIDTH(WIDTH)) dif ();

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    int assertions = 0;
    int failures   = 0;

    // Issue one request and wait for its result; lat = edges after acceptance.
    task automatic do_req(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r,
                          output int lat, output logic dbz);
        @(negedge clk);
        dif.in_valid = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        lat = 0;
        while (!dif.out_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        q = dif.quotient;
        r = dif.remainder;
`ifdef DIV_ZERO_FLAG_EN
        dbz = dif.div_by_zero;
`else
        dbz = 1'b0;
`endif
    endtask

    task automatic pop();
        @(negedge clk);
        dif.out_ready = 1'b1;
        @(negedge clk);
        dif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        assertions++;
        if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 ||
            dif.quotient !== 8'd0 || dif.remainder !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b q=%0d r=%0d, want 1 0 0 0",
                     dif.in_ready, dif.out_valid, dif.quotient, dif.remainder);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        assertions++;
        if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, want 1 0",
                     dif.in_ready, dif.out_valid);
        end
        $display("txn reset done");
    endtask

    task automatic test_basic();
        logic [7:0] va [4] = '{8'd200, 8'd255, 8'd5,  8'd128};
        logic [7:0] vb [4] = '{8'd7,   8'd1,   8'd9,  8'd128};
        logic [7:0] vq [4] = '{8'd28,  8'd255, 8'd0,  8'd1};
        logic [7:0] vr [4] = '{8'd4,   8'd0,   8'd5,  8'd0};
        logic [7:0] q, r;
        logic dbz;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_req(va[i], vb[i], q, r, lat, dbz);
            $display("txn basic %0d/%0d -> q=%0d r=%0d lat=%0d", va[i], vb[i], q, r, lat);
            assertions++;
            if (q !== vq[i] || r !== vr[i]) begin
                failures++;
                $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d, want q=%0d r=%0d",
                         va[i], vb[i], q, r, vq[i], vr[i]);
            end
            assertions++;
            if (lat !== 8) begin
                failures++;
                $display("FAIL basic_latency %0d/%0d: got %0d edges, want 8", va[i], vb[i], lat);
            end
            pop();
            assertions++;
            if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL basic_release: out_valid=%b in_ready=%b, want 0 1",
                         dif.out_valid, dif.in_ready);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r;
        logic dbz;
        int lat;
        int exp_lat;
        logic exp_dbz;
`ifdef DIV_ZERO_FLAG_EN
        exp_lat = 0;
        exp_dbz = 1'b1;
`else
        exp_lat = 8;
        exp_dbz = 1'b0;
`endif
        do_req(8'd77, 8'd0, q, r, lat, dbz);
        $display("txn div_zero 77/0 -> q=%0d r=%0d lat=%0d dbz=%b", q, r, lat, dbz);
        assertions++;
        if (q !== 8'd255 || r !== 8'd77) begin
            failures++;
            $display("FAIL div_zero_result: got q=%0d r=%0d, want q=255 r=77", q, r);
        end
        assertions++;
        if (lat !== exp_lat || dbz !== exp_dbz) begin
            failures++;
            $display("FAIL div_zero_timing: got lat=%0d dbz=%b, want lat=%0d dbz=%b",
                     lat, dbz, exp_lat, exp_dbz);
        end
        pop();
`ifdef DIV_ZERO_FLAG_EN
        assertions++;
        if (dif.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_zero_clear: got dbz=%b, want 0", dif.div_by_zero);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [7:0] q, r;
        logic dbz;
        int lat;
        int bad;
        do_req(8'd100, 8'd3, q, r, lat, dbz);
        $display("txn backpressure 100/3 -> q=%0d r=%0d lat=%0d", q, r, lat);
        assertions++;
        if (q !== 8'd33 || r !== 8'd1 || lat !== 8) begin
            failures++;
            $display("FAIL bp_first: got q=%0d r=%0d lat=%0d, want q=33 r=1 lat=8", q, r, lat);
        end
        // Present a competing request while the result is held.
        @(negedge clk);
        dif.in_valid = 1'b1;
        dif.dividend = 8'd10;
        dif.divisor  = 8'd2;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            assertions++;
            if (dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0 ||
                dif.quotient !== 8'd33 || dif.remainder !== 8'd1) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL bp_hold cycle %0d: ov=%b ir=%b q=%0d r=%0d, want 1 0 33 1",
                             c, dif.out_valid, dif.in_ready, dif.quotient, dif.remainder);
            end
        end
        dif.out_ready = 1'b1;
        @(negedge clk);
        dif.out_ready = 1'b0;
        assertions++;
        if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: ov=%b ir=%b, want 0 1", dif.out_valid, dif.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        lat = 0;
        while (!dif.out_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        $display("txn backpressure 10/2 -> q=%0d r=%0d lat=%0d",
                 dif.quotient, dif.remainder, lat);
        assertions++;
        if (dif.quotient !== 8'd5 || dif.remainder !== 8'd0 || lat !== 8) begin
            failures++;
            $display("FAIL bp_second: got q=%0d r=%0d lat=%0d, want q=5 r=0 lat=8",
                     dif.quotient, dif.remainder, lat);
        end
        pop();
    endtask

    task automatic test_reset_mid_calc();
        logic [7:0] q, r;
        logic dbz;
        int lat;
        @(negedge clk);
        dif.in_valid = 1'b1;
        dif.dividend = 8'd250;
        dif.divisor  = 8'd6;
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        assertions++;
        if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_calc_busy: ir=%b ov=%b, want 0 0", dif.in_ready, dif.out_valid);
        end
        rst = 1'b1;
        #1;
        assertions++;
        if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.quotient !== 8'd0) begin
            failures++;
            $display("FAIL mid_calc_reset: ir=%b ov=%b q=%0d, want 1 0 0",
                     dif.in_ready, dif.out_valid, dif.quotient);
        end
        @(negedge clk);
        rst = 1'b0;
        do_req(8'd250, 8'd6, q, r, lat, dbz);
        $display("txn after_reset 250/6 -> q=%0d r=%0d lat=%0d", q, r, lat);
        assertions++;
        if (q !== 8'd41 || r !== 8'd4 || lat !== 8) begin
            failures++;
            $display("FAIL after_reset_result: got q=%0d r=%0d lat=%0d, want q=41 r=4 lat=8",
                     q, r, lat);
        end
        pop();
    endtask

    task automatic test_random_sweep();
        logic [7:0] a, b, q, r;
        logic [7:0] eq, er;
        logic dbz;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(1, 255));
            eq = a / b;
            er = a % b;
            do_req(a, b, q, r, lat, dbz);
            $display("txn sweep %0d: %0d/%0d -> q=%0d r=%0d", i, a, b, q, r);
            assertions++;
            if (q !== eq || r !== er || lat !== 8) begin
                failures++;
                $display("FAIL sweep %0d/%0d: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=8",
                         a, b, q, r, lat, eq, er);
            end
            assertions++;
            if ((16'(q) * 16'(b) + 16'(r)) !== 16'(a) || !(r < b)) begin
                failures++;
                $display("FAIL sweep_identity %0d/%0d: q=%0d r=%0d violate q*d+r==n, r<d",
                         a, b, q, r);
            end
            pop();
        end
    endtask

    initial begin
        dif.in_valid  = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
